// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings for the memory access sequencer.
// Request kinds as seen on req_kind, the sequencer state enum and the
// latency counter width.
package mem_access_pkg;

    typedef enum logic [1:0] {
        KIND_FETCH = 2'b00,
        KIND_LOAD  = 2'b01,
        KIND_STORE = 2'b10,
        KIND_RSVD  = 2'b11
    } kind_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    localparam int LAT_CNT_W = 4;

endpackage : mem_access_pkg

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences one fetch/load/store at a time between the
// multi-cycle controller and the unified instruction/data memory.
// Optional build macro MEM_ACCESS_MISALIGN_TRAP_EN: when defined, a request
// whose byte address is not word aligned completes immediately with err;
// when undefined, the low two address bits are cleared and the access runs.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_kind,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic              done,
    output logic              err
);

    state_t               state;
    state_t               state_nxt;
    kind_t                kind;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic                 err_q;
    logic                 accept;
    logic                 bad_req;
    logic [ADDR_W-1:0]    addr_in;
    logic                 is_read;
    logic                 last_read;
    logic                 access_end;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign bad_req = (req_kind == KIND_RSVD) || (req_addr[1:0] != 2'b00);
    assign addr_in = req_addr;
`else
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^req_addr[1:0];
    assign bad_req = (req_kind == KIND_RSVD);
    assign addr_in = {req_addr[ADDR_W-1:2], 2'b00};
`endif

    assign accept     = req_valid && req_ready;
    assign is_read    = (kind == KIND_FETCH) || (kind == KIND_LOAD);
    assign last_read  = (lat_cnt == LAT_CNT_W'(READ_LAT - 1));
    // A store always lasts a single ACCESS cycle; reads last READ_LAT cycles.
    assign access_end = is_read ? last_read : 1'b1;
    assign err        = done && err_q;

    // Next-state and strobe decode; strobes are pure functions of state so
    // they fall together with the asynchronous state reset.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        state_nxt = state;
        req_ready = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = bad_req ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_read  = is_read;
                mem_write = (kind == KIND_STORE);
                if (access_end) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request capture on accept; held until the next accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kind      <= KIND_FETCH;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err_q     <= 1'b0;
        end else if (accept) begin
            kind      <= kind_t'(req_kind);
            mem_addr  <= addr_in;
            mem_wdata <= req_wdata;
            err_q     <= bad_req;
        end
    end

    // Read latency counter: cleared on accept, advanced through ACCESS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_cnt <= '0;
        end else if (accept) begin
            lat_cnt <= '0;
        end else if (state == ST_ACCESS && !access_end) begin
            lat_cnt <= lat_cnt + 1'b1;
        end
    end

    // Capture read data into IR or MDR on the edge ending the last read cycle.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: IR and MDR are ordinary registers and are reset, so an
        // interrupted access leaves a zero IR, which decodes as a NOP.
        if (!reset) begin
            ir  <= '0;
            mdr <= '0;
        end else if (state == ST_ACCESS && is_read && last_read) begin
            if (kind == KIND_FETCH) begin
                ir <= mem_rdata;
            end else begin
                mdr <= mem_rdata;
            end
        end
    end

endmodule : mem_access_unit

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: self-checking bench for mem_access_unit.
// Two instances (READ_LAT 1 and 3) are driven one at a time; a transaction
// model derived from the documented cycle timeline predicts strobes, done,
// err, IR and MDR. Honours MEM_ACCESS_MISALIGN_TRAP_EN when defined.
module tb_mem_access_unit;

    logic        clk;
    logic        rst        [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [1:0]  req_kind   [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [31:0] mem_addr   [2];
    logic [31:0] mem_wdata  [2];
    logic        mem_read   [2];
    logic        mem_write  [2];
    logic [31:0] mem_rdata  [2];
    logic [31:0] ir         [2];
    logic [31:0] mdr        [2];
    logic        done       [2];
    logic        err        [2];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ir  [2];
    logic [31:0] exp_mdr [2];
    bit          at_done [2];

    mem_access_unit #(.READ_LAT(1), .DATA_W(32), .ADDR_W(32)) dut_lat1 (
        .clk(clk), .reset(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_kind(req_kind[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_rdata(mem_rdata[0]),
        .ir(ir[0]), .mdr(mdr[0]), .done(done[0]), .err(err[0])
    );

    mem_access_unit #(.READ_LAT(3), .DATA_W(32), .ADDR_W(32)) dut_lat3 (
        .clk(clk), .reset(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_kind(req_kind[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_rdata(mem_rdata[1]),
        .ir(ir[1]), .mdr(mdr[1]), .done(done[1]), .err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Leave instance d idle for n cycles (ends at a negedge in IDLE).
    task automatic idle(int d, int n);
        req_valid[d] = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check1("idle.ready", req_ready[d], 1'b1);
            check1("idle.done", done[d], 1'b0);
        end
        at_done[d] = 1'b0;
    endtask

    // One transaction on instance d. Starts at a negedge in IDLE or DONE and
    // returns at the negedge of the DONE cycle.
    task automatic txn(int d, logic [1:0] kind, logic [31:0] addr, logic [31:0] wdata,
                       bit use_fixed, logic [31:0] fixed_rdata);
        int          n;
        bit          trap;
        bit          is_err;
        logic [31:0] exp_addr;
        logic [31:0] cap;
        cap = '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        trap     = (addr[1:0] != 2'b00);
        exp_addr = addr;
`else
        trap     = 1'b0;
        exp_addr = {addr[31:2], 2'b00};
`endif
        is_err = (kind == 2'b11) || trap;

        req_valid[d] = 1'b1;
        req_kind[d]  = kind;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        if (at_done[d]) begin
            // Presented during DONE: must not be taken until the IDLE edge.
            @(posedge clk);
            @(negedge clk);
            check1("done_req.ready", req_ready[d], 1'b1);
            check1("done_req.read", mem_read[d], 1'b0);
            check1("done_req.write", mem_write[d], 1'b0);
            check1("done_req.done", done[d], 1'b0);
        end else begin
            check1("idle.ready", req_ready[d], 1'b1);
        end
        @(posedge clk);   // accept edge: cycle 0
        @(negedge clk);   // cycle 1

        if (is_err) begin
            req_valid[d] = 1'b0;
            check1("err.done", done[d], 1'b1);
            check1("err.err", err[d], 1'b1);
            check1("err.read", mem_read[d], 1'b0);
            check1("err.write", mem_write[d], 1'b0);
            check1("err.ready", req_ready[d], 1'b0);
            check("err.ir", ir[d], exp_ir[d]);
            check("err.mdr", mdr[d], exp_mdr[d]);
        end else begin
            n = (kind == 2'b10) ? 1 : lat_of(d);
            for (int c = 1; c <= n; c++) begin
                check1("acc.ready", req_ready[d], 1'b0);
                check1("acc.done", done[d], 1'b0);
                check1("acc.err", err[d], 1'b0);
                check1("acc.read", mem_read[d], kind != 2'b10);
                check1("acc.write", mem_write[d], kind == 2'b10);
                check("acc.addr", mem_addr[d], exp_addr);
                check("acc.wdata", mem_wdata[d], wdata);
                mem_rdata[d] = (use_fixed && c == n) ? fixed_rdata : $urandom;
                cap = mem_rdata[d];
                // Busy-time noise on the request port must be ignored.
                req_valid[d] = 1'($urandom);
                req_kind[d]  = 2'($urandom);
                req_addr[d]  = $urandom;
                req_wdata[d] = $urandom;
                @(negedge clk);
            end
            if (kind == 2'b00) exp_ir[d] = cap;
            if (kind == 2'b01) exp_mdr[d] = cap;
            req_valid[d] = 1'b0;
            mem_rdata[d] = $urandom;
            check1("done.done", done[d], 1'b1);
            check1("done.err", err[d], 1'b0);
            check1("done.read", mem_read[d], 1'b0);
            check1("done.write", mem_write[d], 1'b0);
            check1("done.ready", req_ready[d], 1'b0);
            check("done.ir", ir[d], exp_ir[d]);
            check("done.mdr", mdr[d], exp_mdr[d]);
            check("done.addr", mem_addr[d], exp_addr);
            check("done.wdata", mem_wdata[d], wdata);
        end
        at_done[d] = 1'b1;
    endtask

    // Load on instance d with reset pulsed low in cycle 2 of the access.
    task automatic reset_mid_load(int d, logic [31:0] addr);
        req_valid[d] = 1'b1;
        req_kind[d]  = 2'b01;
        req_addr[d]  = addr;
        req_wdata[d] = $urandom;
        check1("rst_mid.ready", req_ready[d], 1'b1);
        @(posedge clk);
        @(negedge clk);   // cycle 1
        req_valid[d] = 1'b0;
        mem_rdata[d] = $urandom;
        check1("rst_mid.read_c1", mem_read[d], 1'b1);
        @(negedge clk);   // cycle 2
        mem_rdata[d] = $urandom;
        check1("rst_mid.read_c2", mem_read[d], 1'b1);
        rst[d] = 1'b0;
        #1;
        check1("rst_mid.read_drop", mem_read[d], 1'b0);
        check1("rst_mid.write", mem_write[d], 1'b0);
        check("rst_mid.mdr", mdr[d], 32'h0);
        check("rst_mid.ir", ir[d], 32'h0);
        exp_ir[d]  = '0;
        exp_mdr[d] = '0;
        @(negedge clk);
        rst[d] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check1("rst_mid.no_done", done[d], 1'b0);
            check1("rst_mid.no_read", mem_read[d], 1'b0);
            check1("rst_mid.ready", req_ready[d], 1'b1);
        end
        at_done[d] = 1'b0;
    endtask

    initial begin
        logic [1:0]  k;
        logic [31:0] a;
        for (int d = 0; d < 2; d++) begin
            rst[d]       = 1'b0;
            req_valid[d] = 1'b0;
            req_kind[d]  = 2'b00;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            mem_rdata[d] = '0;
            exp_ir[d]    = '0;
            exp_mdr[d]   = '0;
            at_done[d]   = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check1("reset.ready", req_ready[d], 1'b1);
            check("reset.ir", ir[d], 32'h0);
            check("reset.mdr", mdr[d], 32'h0);
            check1("reset.read", mem_read[d], 1'b0);
            check1("reset.write", mem_write[d], 1'b0);
            check1("reset.done", done[d], 1'b0);
            check1("reset.err", err[d], 1'b0);
            check("reset.addr", mem_addr[d], 32'h0);
            check("reset.wdata", mem_wdata[d], 32'h0);
        end

        // Directed steps on the READ_LAT=1 instance.
        txn(0, 2'b00, 32'h0000_0004, 32'h0, 1'b1, 32'h2405_CFC7);
        check("fetch.ir_value", ir[0], 32'h2405_CFC7);
        check("fetch.mdr_untouched", mdr[0], 32'h0);
        txn(0, 2'b10, 32'h0000_0080, 32'hDEAD_BEEF, 1'b0, 32'h0);
        check("store.ir_kept", ir[0], 32'h2405_CFC7);
        txn(0, 2'b01, 32'h0000_0082, 32'h0, 1'b0, 32'h0);
        txn(0, 2'b11, 32'h0000_0010, 32'h0, 1'b0, 32'h0);
        idle(0, 1);

        // Directed steps on the READ_LAT=3 instance.
        txn(1, 2'b01, 32'h0000_0100, 32'h0, 1'b0, 32'h0);
        txn(1, 2'b10, 32'h0000_0080, 32'hDEAD_BEEF, 1'b0, 32'h0);
        txn(1, 2'b01, 32'h0000_0082, 32'h0, 1'b0, 32'h0);
        txn(1, 2'b00, 32'h0000_0008, 32'h0, 1'b0, 32'h0);
        idle(1, 2);
        reset_mid_load(1, 32'h0000_0200);
        txn(1, 2'b00, 32'h0000_000C, 32'h0, 1'b0, 32'h0);
        idle(1, 1);

        // Randomized traffic, mostly valid kinds, with occasional idle gaps.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 30; i++) begin
                k = 2'($urandom_range(0, 3));
                a = $urandom;
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                txn(d, k, a, $urandom, 1'b0, 32'h0);
                if ($urandom_range(0, 4) == 0) idle(d, $urandom_range(1, 3));
            end
            idle(d, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_access_unit

// File: doc/mem_access_unit.md
# mem_access_unit

Sequencer between the multi-cycle controller and the unified instruction/data memory. It accepts one fetch, load or store request at a time over a valid/ready handshake. It drives the memory's address, write-data and read/write strobes for the required number of cycles, then captures read data into the instruction register (IR) or the memory data register (MDR). Completion is signalled with a one-cycle `done` pulse.

## Interface
- `READ_LAT`, default 1: cycles `mem_read` is held before read data is captured; legal range 1..15.
- `DATA_W`, default 32: data width.
- `ADDR_W`, default 32: byte-address width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: controller request present.
- `req_ready` out 1: unit idle and able to accept a request.
- `req_kind` in 2: request type; 00 fetch, 01 load, 10 store, 11 reserved.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in DATA_W: store data.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_rdata` in DATA_W: memory read data (combinational from the memory).
- `ir` out DATA_W: instruction register.
- `mdr` out DATA_W: memory data register.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: error flag, valid with `done`.

## Operation
- States are IDLE, ACCESS and DONE.
  - IDLE → ACCESS on `req_valid && req_ready`.
  - ACCESS → DONE after the access completes.
  - DONE → IDLE unconditionally.
- `req_ready` is 1 only in IDLE. `req_valid` in any other state is ignored, and no request is queued.
- On accept, the unit registers the kind, `mem_addr` (from `req_addr`) and `mem_wdata` (from `req_wdata`). These registers hold their values until the next accept.
- Fetch and load:
  - `mem_read` is 1 for exactly READ_LAT ACCESS cycles, counted by a 4-bit latency counter.
  - On the edge ending the last of those cycles, `mem_rdata` is written to `ir` (fetch) or `mdr` (load).
  - The other register is unchanged.
- Store: `mem_write` is 1 for exactly one ACCESS cycle; `ir` and `mdr` are unchanged.
- Reserved kind 11: the unit goes IDLE → DONE directly (no ACCESS cycle, no strobes). `err` = 1 in that DONE cycle.
- `mem_read` and `mem_write` are never 1 together and are 0 outside ACCESS.
- `done` is 1 only in the DONE state. `err` is 0 whenever `done` is 0.

## Timing
- Reset (`reset` = 0): state IDLE; `req_ready` = 1 once released.
  - `ir`, `mdr`, `mem_addr` and `mem_wdata` reset to 0 (an IR of 0 decodes as a NOP).
  - `mem_read`, `mem_write`, `done` and `err` reset to 0.
- Latency (accept edge = cycle 0):
  - Fetch/load: ACCESS in cycles 1..READ_LAT; `done` in cycle READ_LAT+1; next accept possible in cycle READ_LAT+2.
  - Store: ACCESS in cycle 1; `done` in cycle 2.
- Reset asserted mid-access: strobes drop asynchronously, and any capture or write in progress is abandoned. `ir` and `mdr` go to 0.
- A request presented during the DONE cycle is not accepted. It is accepted on the first IDLE edge on which it is still valid.
- Address wrap: no incrementing is done, so the address is passed through unmodified apart from the misalignment handling below.

## Configuration
- `MEM_ACCESS_MISALIGN_TRAP_EN` defined:
  - A request with `req_addr[1:0]` ≠ 0 is routed IDLE → DONE with no strobes.
  - `err` = 1 with `done`; `ir` and `mdr` are unchanged.
- `MEM_ACCESS_MISALIGN_TRAP_EN` undefined:
  - `mem_addr[1:0]` is forced to 00 and the access proceeds normally.
  - `err` is asserted only for reserved kind 11.

## Structure
- Package `mem_access_pkg` holds:
  - the `req_kind` encodings (KIND_FETCH, KIND_LOAD, KIND_STORE, KIND_RSVD);
  - the state enum;
  - the latency counter width constant (4).
- Single module; no sub-module is warranted. The latency counter stays inline.

## Test plan
- Reset, then release → `req_ready` = 1 and `ir` = `mdr` = 0, with all strobes 0.
- Fetch, addr 0x0000_0004, `mem_rdata` = 0x2405CFC7, READ_LAT = 1 → `mem_read` high in cycle 1 only; `ir` = 0x2405CFC7 and `done` in cycle 2; `mdr` unchanged.
- Store, addr 0x80, data 0xDEADBEEF → `mem_write` high for exactly one cycle with `mem_addr` = 0x80 and `mem_wdata` = 0xDEADBEEF; `done` in cycle 2.
- Load with READ_LAT = 3, `mem_rdata` changed each cycle → `mem_read` high for cycles 1..3; `mdr` equals the cycle-3 value; `done` in cycle 4.
- Load to 0x82:
  - macro defined → `done` and `err` in cycle 1, no strobes;
  - macro undefined → `mem_addr` = 0x80 and normal completion with `err` = 0.
- `reset` pulsed low in cycle 2 of a READ_LAT = 3 load → `mem_read` drops immediately, `mdr` = 0, and no `done` pulse occurs.
